l1_cache: RTL

- Direct-mapped, write-back, write-allocate L1 cache.
- It is the responder to the CPU datapath's cache port: the CPU issues read/write requests and holds them until this block returns resp.
- It is the initiator on a line-granular physical-memory port toward L2/arbiter.
- One instance each for I-side and D-side. The I-side simply never drives mem_write.

---
 rtl/lc3b_types.sv | 20 ++
 rtl/cache_array.sv | 39 +++
 rtl/l1_cache.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the L1 cache field and state types.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_datbus;
  typedef logic [15:0]  lc3b_mem_wmask;

  localparam int C_SET_BITS = 3;
  localparam int C_OFF_BITS = 4;
  localparam int C_TAG_BITS = 16 - C_OFF_BITS - C_SET_BITS;

  typedef logic [C_TAG_BITS-1:0] lc3b_c_tag;
  typedef logic [C_SET_BITS-1:0] lc3b_c_index;
  typedef logic [C_OFF_BITS-1:0] lc3b_c_offset;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } lc3b_cache_state;
endpackage

// File: rtl/cache_array.sv
// Per-set storage array: synchronous write, asynchronous read,
// contents optionally cleared by reset.
module cache_array #(
  parameter int WIDTH    = 1,
  parameter int SET_BITS = 3,
  parameter bit RESET_EN = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [SET_BITS-1:0] index,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout
);
  localparam int SETS = 2 ** SET_BITS;

  logic [WIDTH-1:0] mem [SETS];

  if (RESET_EN) begin : g_rst
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < SETS; i++)
          mem[i] <= '0;
      end else if (we) begin
        mem[index] <= din;
      end
    end
  end else begin : g_norst
    logic unused_reset;
    assign unused_reset = reset;

    always_ff @(posedge clk) begin
      if (we)
        mem[index] <= din;
    end
  end

  assign dout = mem[index];
endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back write-allocate L1 cache with a
// line-granular physical-memory port.
module l1_cache
  import lc3b_types::*;
#(
  parameter int SET_BITS   = 3,
  parameter int LINE_BYTES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_addr,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_en,
  input  lc3b_datbus    mem_wdata,
  output lc3b_datbus    mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_addr,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_datbus    pmem_wdata,
  input  lc3b_datbus    pmem_rdata,
  input  logic          pmem_resp
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = 16 - OFF_W - SET_BITS;

  lc3b_cache_state state, next;

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tg, tag_q;
  lc3b_datbus          data_q, data_in, merged;
  logic valid_q, dirty_q, dirty_in;
  logic data_we, tag_we, valid_we, dirty_we;
  logic hit, req;
  logic unused_off;

  assign idx = mem_addr[OFF_W+SET_BITS-1:OFF_W];
  assign tg  = mem_addr[15:OFF_W+SET_BITS];
  assign unused_off = ^mem_addr[OFF_W-1:0];

  assign hit = valid_q & (tag_q == tg);
  assign req = mem_read | mem_write;

  assign mem_rdata  = data_q;
  assign pmem_wdata = data_q;

  cache_array #(.WIDTH(128), .SET_BITS(SET_BITS)) u_data (
    .clk(clk), .reset(reset), .we(data_we), .index(idx),
    .din(data_in), .dout(data_q)
  );

  cache_array #(.WIDTH(TAG_W), .SET_BITS(SET_BITS)) u_tag (
    .clk(clk), .reset(reset), .we(tag_we), .index(idx),
    .din(tg), .dout(tag_q)
  );

  cache_array #(.WIDTH(1), .SET_BITS(SET_BITS), .RESET_EN(1'b1)) u_valid (
    .clk(clk), .reset(reset), .we(valid_we), .index(idx),
    .din(1'b1), .dout(valid_q)
  );

  cache_array #(.WIDTH(1), .SET_BITS(SET_BITS), .RESET_EN(1'b1)) u_dirty (
    .clk(clk), .reset(reset), .we(dirty_we), .index(idx),
    .din(dirty_in), .dout(dirty_q)
  );

  always_comb begin
    merged = data_q;
    for (int i = 0; i < 16; i++)
      if (mem_byte_en[i])
        merged[8*i +: 8] = mem_wdata[8*i +: 8];
  end

  always_comb begin
    next       = state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    data_we    = 1'b0;
    data_in    = merged;
    tag_we     = 1'b0;
    valid_we   = 1'b0;
    dirty_we   = 1'b0;
    dirty_in   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            data_we  = 1'b1;
            dirty_we = 1'b1;
            dirty_in = 1'b1;
          end
        end else if (req) begin
          next = (valid_q && dirty_q) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_q, idx, {OFF_W{1'b0}}};
        if (pmem_resp)
          next = req ? ALLOCATE : IDLE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        pmem_addr = {mem_addr[15:OFF_W], {OFF_W{1'b0}}};
        if (pmem_resp) begin
          data_we  = 1'b1;
          data_in  = pmem_rdata;
          tag_we   = 1'b1;
          valid_we = 1'b1;
          dirty_we = 1'b1;
          next     = IDLE;
        end
      end
      default: next = IDLE;
    endcase
    // Reset drops any in-flight pmem request in the same cycle.
    if (reset) begin
      next       = IDLE;
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      pmem_addr  = '0;
      data_we    = 1'b0;
      tag_we     = 1'b0;
      valid_we   = 1'b0;
      dirty_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(mem_read && mem_write))
        else $error("l1_cache: read and write requested together");
  end
endmodule
